// File: rtl/snake_pkg.sv
// Shared state encoding for the snake game controller and the display/VGA code.
package snake_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DIE     = 3'b000,
    ST_PLAY    = 3'b001,
    ST_START   = 3'b010,
    ST_WIN     = 3'b011,
    ST_PAUSE   = 3'b100,
    ST_RESPAWN = 3'b101
  } state_e;

  function automatic logic is_delay_state(input state_e s);
    return (s == ST_DIE) || (s == ST_WIN) || (s == ST_RESPAWN);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: evt is high one cycle after d goes 0->1.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic evt
);

  logic prev_q, prev_d;
  logic evt_q, evt_d;

  always_comb begin
    prev_d = d;
    evt_d  = d & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level snake game state controller: START/PLAY/PAUSE/RESPAWN/DIE/WIN with
// multi-life handling, edge-triggered keys and timed end/respawn phases.
module game_state_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned BTN_W          = 4,
  parameter int unsigned BTN_ACTIVE_LOW = 1,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned END_DELAY      = 10000000,
  parameter int unsigned RESPAWN_DELAY  = 2000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BTN_W-1:0]   btn,
  input  logic               pause_btn,
  input  logic               die,
  input  logic               win,
  output logic [STATE_W-1:0] state,
  output logic [2:0]         lives,
  output logic               game_clr,
  output logic               delay_busy
);

  localparam logic [2:0]       LIVES_INIT   = 3'(LIVES);
  localparam logic [CNT_W-1:0] END_LAST     = CNT_W'(END_DELAY - 1);
  localparam logic [CNT_W-1:0] RESPAWN_LAST = CNT_W'(RESPAWN_DELAY - 1);

  logic key_any;
  logic key_evt;
  logic pause_evt;

  assign key_any = (BTN_ACTIVE_LOW != 0) ? (btn != '1) : (btn != '0);

  edge_rise u_key_edge (
    .clk (clk),
    .rst (rst),
    .d   (key_any),
    .evt (key_evt)
  );

  edge_rise u_pause_edge (
    .clk (clk),
    .rst (rst),
    .d   (pause_btn),
    .evt (pause_evt)
  );

  state_e           state_q, state_d;
  logic [2:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             game_clr_q, game_clr_d;

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    game_clr_d = 1'b0;
    cnt_d      = cnt_q + CNT_W'(1);

    case (state_q)
      ST_START: begin
        if (key_evt) begin
          state_d    = ST_PLAY;
          game_clr_d = 1'b1;
          lives_d    = LIVES_INIT;
        end
      end
      ST_PLAY: begin
        if (die) begin
          if (lives_q > 3'd1) begin
            state_d = ST_RESPAWN;
            lives_d = lives_q - 3'd1;
          end else begin
            state_d = ST_DIE;
            lives_d = 3'd0;
          end
        end else if (win) begin
          state_d = ST_WIN;
        end else if (pause_evt) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_evt) state_d = ST_PLAY;
      end
      ST_RESPAWN: begin
        if (cnt_q == RESPAWN_LAST) begin
          state_d    = ST_PLAY;
          game_clr_d = 1'b1;
        end
      end
      ST_DIE, ST_WIN: begin
        if (cnt_q == END_LAST) begin
          state_d = ST_START;
          lives_d = LIVES_INIT;
        end
      end
      default: state_d = ST_START;
    endcase

    // Counter only runs while dwelling in a timed state; any transition restarts it.
    if ((state_d != state_q) || !is_delay_state(state_q)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_START;
      lives_q    <= LIVES_INIT;
      cnt_q      <= '0;
      game_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      cnt_q      <= cnt_d;
      game_clr_q <= game_clr_d;
    end
  end

  assign state      = state_q;
  assign lives      = lives_q;
  assign game_clr   = game_clr_q;
  assign delay_busy = is_delay_state(state_q);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus random stimulus, all checked
// every cycle against a behavioural model built on edge counts and input history.
module tb_game_state_ctrl;

  localparam int LIVES         = 2;
  localparam int END_DELAY     = 8;
  localparam int RESPAWN_DELAY = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'hF;
  logic       pause_btn = 1'b0;
  logic       die = 1'b0;
  logic       win = 1'b0;
  logic [2:0] state;
  logic [2:0] lives;
  logic       game_clr;
  logic       delay_busy;

  int vectors = 0;
  int miscompares = 0;

  game_state_ctrl #(
    .BTN_W          (4),
    .BTN_ACTIVE_LOW (1),
    .LIVES          (LIVES),
    .END_DELAY      (END_DELAY),
    .RESPAWN_DELAY  (RESPAWN_DELAY),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .pause_btn  (pause_btn),
    .die        (die),
    .win        (win),
    .state      (state),
    .lives      (lives),
    .game_clr   (game_clr),
    .delay_busy (delay_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. Codes: 0 DIE, 1 PLAY, 2 START, 3 WIN, 4 PAUSE, 5 RESPAWN.
  int m_state = 2;
  int m_lives = LIVES;
  int m_clr = 0;
  int edge_n = 0;
  int entry_edge = 0;
  bit mv = 0;
  bit key_h0 = 0, key_h1 = 0, pau_h0 = 0, pau_h1 = 0;

  always @(posedge clk) begin
    int nxt;
    bit kevt, pevt, key_now;
    key_now = (btn != 4'hF);
    if (rst) begin
      m_state = 2; m_lives = LIVES; m_clr = 0;
      key_h0 = 0; key_h1 = 0; pau_h0 = 0; pau_h1 = 0;
      entry_edge = edge_n;
      mv = 1;
    end else begin
      kevt = key_h0 && !key_h1;
      pevt = pau_h0 && !pau_h1;
      nxt = m_state;
      m_clr = 0;
      case (m_state)
        2: if (kevt) begin nxt = 1; m_clr = 1; m_lives = LIVES; end
        1: begin
          if (die) begin
            if (m_lives > 1) begin nxt = 5; m_lives = m_lives - 1; end
            else begin nxt = 0; m_lives = 0; end
          end else if (win) nxt = 3;
          else if (pevt) nxt = 4;
        end
        4: if (pevt) nxt = 1;
        5: if (edge_n - entry_edge == RESPAWN_DELAY) begin nxt = 1; m_clr = 1; end
        0, 3: if (edge_n - entry_edge == END_DELAY) begin nxt = 2; m_lives = LIVES; end
        default: nxt = 2;
      endcase
      if (nxt != m_state) entry_edge = edge_n;
      m_state = nxt;
      key_h1 = key_h0; key_h0 = key_now;
      pau_h1 = pau_h0; pau_h0 = pause_btn;
    end
    edge_n++;
  end

  always @(negedge clk) begin
    if (mv) begin
      check("state", int'(state), m_state);
      check("lives", int'(lives), m_lives);
      check("game_clr", int'(game_clr), m_clr);
      check("delay_busy", int'(delay_busy), int'(m_state == 0 || m_state == 3 || m_state == 5));
    end
  end

  task automatic go_play();
    btn = 4'hF;
    repeat (2) @(negedge clk);
    btn = 4'hE;
    repeat (2) @(negedge clk);
    check("go_play_state", int'(state), 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_state", int'(state), 2);
    check("rst_lives", int'(lives), 2);
    check("rst_clr", int'(game_clr), 0);

    // 1: idle keys keep START, then a press enters PLAY two edges later
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_start", int'(state), 2);
    end
    btn = 4'hE;
    @(negedge clk);
    check("key_lat1", int'(state), 2);
    @(negedge clk);
    check("key_play", int'(state), 1);
    check("key_clr", int'(game_clr), 1);
    @(negedge clk);
    check("key_clr_off", int'(game_clr), 0);
    repeat (5) begin
      @(negedge clk);
      check("hold_play", int'(state), 1);
    end

    // 2: single die pulse with a spare life
    die = 1'b1;
    @(negedge clk);
    die = 1'b0;
    for (int i = 0; i < RESPAWN_DELAY; i++) begin
      check("respawn_state", int'(state), 5);
      check("respawn_busy", int'(delay_busy), 1);
      check("respawn_lives", int'(lives), 1);
      @(negedge clk);
    end
    check("respawn_exit", int'(state), 1);
    check("respawn_clr", int'(game_clr), 1);
    @(negedge clk);
    check("respawn_clr_off", int'(game_clr), 0);

    // 3: last life lost, held key gives no re-entry
    die = 1'b1;
    @(negedge clk);
    for (int i = 0; i < END_DELAY; i++) begin
      check("die_state", int'(state), 0);
      check("die_lives", int'(lives), 0);
      @(negedge clk);
    end
    check("die_exit", int'(state), 2);
    check("die_reload", int'(lives), 2);
    die = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("held_key_start", int'(state), 2);
    end
    go_play();

    // 4: die beats win
    die = 1'b1; win = 1'b1;
    @(negedge clk);
    die = 1'b0; win = 1'b0;
    check("diewin_respawn", int'(state), 5);
    repeat (RESPAWN_DELAY) @(negedge clk);
    check("diewin_back", int'(state), 1);
    die = 1'b1; win = 1'b1;
    @(negedge clk);
    die = 1'b0; win = 1'b0;
    check("diewin_die", int'(state), 0);
    repeat (END_DELAY) @(negedge clk);
    check("diewin_start", int'(state), 2);
    go_play();

    // 5: pause ignores die/win; pause_evt loses to win
    pause_btn = 1'b1;
    @(negedge clk);
    pause_btn = 1'b0;
    @(negedge clk);
    check("pause_enter", int'(state), 4);
    die = 1'b1; win = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("pause_hold", int'(state), 4);
    end
    die = 1'b0; win = 1'b0;
    pause_btn = 1'b1;
    @(negedge clk);
    pause_btn = 1'b0;
    @(negedge clk);
    check("pause_exit", int'(state), 1);
    check("pause_exit_clr", int'(game_clr), 0);
    pause_btn = 1'b1;
    @(negedge clk);
    pause_btn = 1'b0;
    win = 1'b1;
    @(negedge clk);
    win = 1'b0;
    check("win_over_pause", int'(state), 3);

    // 6: reset mid-WIN, then a fresh WIN lasts the full delay
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midwin_rst_state", int'(state), 2);
    check("midwin_rst_lives", int'(lives), 2);
    go_play();
    win = 1'b1;
    for (int i = 0; i < END_DELAY; i++) begin
      @(negedge clk);
      check("full_win", int'(state), 3);
    end
    @(negedge clk);
    check("full_win_exit", int'(state), 2);
    win = 1'b0;

    // Random phase, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0)
        btn = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      pause_btn = ($urandom_range(0, 9) == 0);
      die = ($urandom_range(0, 29) == 0);
      win = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Parametrised successor to the snake game's top-level state controller. Sequences START, PLAY, PAUSE, RESPAWN, DIE (game over) and WIN. Adds a multi-life system, a pause mode, edge-triggered key detection, and configurable end-of-game and respawn delays. Sits between the keypad/button front end and the snake/food/display logic, which consume `state`, `lives` and `game_clr`.

Parameters:
- BTN_W, 4, width of the start-key bus.
- BTN_ACTIVE_LOW, 1, 1: a key is pressed when its bit is 0; 0: pressed when its bit is 1.
- LIVES, 3, lives per game; legal range 1..7.
- END_DELAY, 10000000, cycles spent in DIE or WIN before returning to START; must be ≥1.
- RESPAWN_DELAY, 2000000, cycles spent in RESPAWN before resuming PLAY; must be ≥1.
- CNT_W, 32, delay counter width; must hold max(END_DELAY, RESPAWN_DELAY).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- btn, input, BTN_W, raw start keys; already debounced upstream.
- pause_btn, input, 1, pause toggle key; active-high; debounced upstream.
- die, input, 1, collision flag from snake logic; level-sensitive.
- win, input, 1, win flag from snake logic; level-sensitive.
- state, output, 3, current state code (see package).
- lives, output, 3, remaining lives.
- game_clr, output, 1, one-cycle pulse telling the snake/food logic to reinitialise.
- delay_busy, output, 1, high while in DIE, WIN or RESPAWN.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (applied on a clk edge with rst=1): state=START, lives=LIVES, delay counter=0, game_clr=0, edge-detect history registers=0. Reset mid-delay or mid-game aborts immediately.
- Key press definition: key_any = (btn != all-ones) if BTN_ACTIVE_LOW, else (btn != 0).
- Key events: key_evt = rising edge of key_any; pause_evt = rising edge of pause_btn. Each is registered, so an event appears one cycle after the input edge. A key held through a state change never generates a new event.
- State codes: DIE=000, PLAY=001, START=010, WIN=011, PAUSE=100, RESPAWN=101. Codes 110/111 are illegal and go to START on the next cycle.
- START: on key_evt → PLAY, pulse game_clr for the same cycle state becomes PLAY, lives=LIVES. No other input has effect.
- PLAY, evaluated in priority order die > win > pause_evt:
  - die and lives>1 → RESPAWN, lives decrements by 1.
  - die and lives==1 → DIE, lives=0.
  - win → WIN.
  - pause_evt → PAUSE.
- PAUSE: die and win are ignored. pause_evt → PLAY with no game_clr. key_evt is ignored.
- RESPAWN: counts RESPAWN_DELAY cycles, then → PLAY with a game_clr pulse. lives is unchanged.
- DIE / WIN: count END_DELAY cycles, then → START. lives is reloaded to LIVES on the START entry. Keys are ignored.
- Delay timing: the counter is cleared on every state transition. A state entered at edge t is left at edge t+DELAY exactly, so state holds for DELAY cycles.
- delay_busy is combinationally decoded from state.
- game_clr is registered and high for exactly 1 cycle per assertion. It never asserts in PAUSE, DIE or WIN.

Decomposition:
- Package `snake_pkg` holds the state localparams (ST_DIE, ST_PLAY, ST_START, ST_WIN, ST_PAUSE, ST_RESPAWN) and STATE_W=3. Display/VGA code imports it.
- Sub-module `edge_rise` (1-bit registered rising-edge detector, sync reset), instantiated twice: once for key_any, once for pause_btn.

Test Plan (params LIVES=2, END_DELAY=8, RESPAWN_DELAY=4, BTN_ACTIVE_LOW=1):
1. Reset, then btn=4'b1111 for 20 cycles → state=010 throughout, lives=2, game_clr=0. Drive btn=4'b1110 → state=001 two cycles after the btn edge, with game_clr high for exactly that 1 cycle. Holding btn low keeps state at 001.
2. In PLAY, pulse die for 1 cycle → state=101, lives=1, delay_busy=1 for 4 cycles. Then state=001, game_clr pulse, lives=1.
3. In PLAY with lives=1, hold die high → state=000, lives=0 for exactly 8 cycles. Then state=010, lives=2. Holding btn low throughout gives no re-entry to PLAY until btn is released and pressed again.
4. In PLAY, assert die and win on the same cycle → state=101 (die wins). With lives=1 and die+win together → state=000.
5. In PLAY, pulse pause_btn → state=100. Assert die and win for 5 cycles → state stays 100. Pulse pause_btn again → state=001, game_clr=0. A pause_evt on the same cycle as win → state=011.
6. Assert rst mid-WIN at counter=5 → next cycle state=010, lives=2. A fresh win is then held for the full 8 cycles, not 3.
